// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its command sequencer.
//   OP_*      : ALU opcode encodings (ctrl input of the ALU)
//   state_t   : sequencer FSM states
//   is_arith  : 1 for opcodes whose ALU overflow output is meaningful
package alu_pkg;

   localparam int OP_W_DEF = 3;

   localparam logic [OP_W_DEF-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W_DEF-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W_DEF-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W_DEF-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W_DEF-1:0] OP_XOR  = 3'b100;
   localparam logic [OP_W_DEF-1:0] OP_NAND = 3'b101;
   localparam logic [OP_W_DEF-1:0] OP_NOR  = 3'b110;
   localparam logic [OP_W_DEF-1:0] OP_NOT  = 3'b111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   // The ALU drives garbage on overflow for logic ops; only add/sub count.
   function automatic logic is_arith(input logic [OP_W_DEF-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Front end for the combinational ALU: accepts one command at a time over a
// valid/ready stream, drives the ALU for a two-cycle enable window, captures
// result/flags, keeps an accumulator plus sticky overflow, and returns one
// response per command over a second valid/ready stream.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a, cmd_b        opcode and operands
//   cmd_use_acc                 take operand A from the accumulator
//   acc_clr                     sync clear of accumulator and sticky overflow
//   alu_a, alu_b, alu_ctrl,
//   alu_enable                  registered drive into the ALU
//   alu_result, alu_zero,
//   alu_overflow                ALU outputs, sampled on the capture edge
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero,
//   rsp_overflow                captured response (overflow masked per op)
//   acc_out, ovf_sticky         accumulator and sticky overflow
//   busy                        FSM not in IDLE
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int                DATA_W    = 4,
   parameter int                OP_W      = 3,
   parameter logic [DATA_W-1:0] ACC_RESET = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic              cmd_use_acc,
   input  logic              acc_clr,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_ctrl,
   output logic              alu_enable,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic              alu_overflow,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero,
   output logic              rsp_overflow,
   output logic [DATA_W-1:0] acc_out,
   output logic              ovf_sticky,
   output logic              busy
);

   state_t state;
   logic   ovf_masked;

   // alu_ctrl holds the in-flight opcode, so it qualifies the ALU overflow.
   assign ovf_masked = is_arith(alu_ctrl) & alu_overflow;

   // Both decoded straight from the state flop: one command in flight.
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // Command FSM. Operands are registered on the accept edge and held until
   // the next accept; alu_enable spans ISSUE and CAPTURE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_ctrl     <= '0;
         alu_enable   <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_zero     <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  // acc_out here is the pre-clear value even if acc_clr is high.
                  alu_a      <= cmd_use_acc ? acc_out : cmd_a;
                  alu_b      <= cmd_b;
                  alu_ctrl   <= cmd_op;
                  alu_enable <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               alu_enable   <= 1'b0;
               rsp_result   <= alu_result;
               rsp_zero     <= alu_zero;
               rsp_overflow <= ovf_masked;
               rsp_valid    <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state      <= IDLE;
               alu_enable <= 1'b0;
               rsp_valid  <= 1'b0;
            end
         endcase
      end
   end

   // Accumulator and sticky overflow. On the capture edge the clear is
   // applied before the OR, so a coincident acc_clr leaves only the new flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out    <= ACC_RESET;
         ovf_sticky <= 1'b0;
      end else if (state == CAPTURE) begin
         acc_out    <= alu_result;
         ovf_sticky <= (ovf_sticky & ~acc_clr) | ovf_masked;
      end else if (acc_clr) begin
         acc_out    <= ACC_RESET;
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural 4-bit ALU in the loop.
// Directed commands push expected responses into a queue; a negedge monitor
// pops and compares on every response handshake.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_use_acc, acc_clr;
   logic [2:0] cmd_op;
   logic [3:0] cmd_a, cmd_b;
   logic [3:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_ctrl;
   logic       alu_enable, alu_zero, alu_overflow;
   logic       rsp_valid, rsp_ready, rsp_zero, rsp_overflow;
   logic [3:0] rsp_result, acc_out;
   logic       ovf_sticky, busy;

   always #5 clk = ~clk;

   alu_cmd_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_enable(alu_enable),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
      .acc_out(acc_out), .ovf_sticky(ovf_sticky), .busy(busy)
   );

   // ALU model: outputs zero when disabled; overflow is carry/borrow for
   // add/sub and deliberately 1 for logic ops (undefined there).
   logic [4:0] wide;
   always_comb begin
      wide         = '0;
      alu_result   = '0;
      alu_overflow = 1'b0;
      alu_zero     = 1'b0;
      if (alu_enable) begin
         case (alu_ctrl)
            3'b000: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = wide[3:0]; alu_overflow = wide[4]; end
            3'b001: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_result = wide[3:0]; alu_overflow = wide[4]; end
            3'b010: begin alu_result = alu_a & alu_b;    alu_overflow = 1'b1; end
            3'b011: begin alu_result = alu_a | alu_b;    alu_overflow = 1'b1; end
            3'b100: begin alu_result = alu_a ^ alu_b;    alu_overflow = 1'b1; end
            3'b101: begin alu_result = ~(alu_a & alu_b); alu_overflow = 1'b1; end
            3'b110: begin alu_result = ~(alu_a | alu_b); alu_overflow = 1'b1; end
            default: begin alu_result = ~alu_a;          alu_overflow = 1'b1; end
         endcase
         alu_zero = (alu_result == 4'd0);
      end
   end

   typedef struct {
      logic [3:0] res;
      logic       z;
      logic       o;
      logic [3:0] acc;
      logic       st;
      int         t_acc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   en_cnt = 0;
   int   last_acc = 0;
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: latency on the rising edge of rsp_valid, full compare on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         en_cnt = 0;
         prev_v = 1'b0;
      end else begin
         if (alu_enable) en_cnt++;
         if (rsp_valid && !prev_v) begin
            if (sb.size() == 0) chk("unexpected_rsp_valid", 1, 0);
            else                chk("latency", cyc - sb[0].t_acc, 3);
         end
         if (rsp_valid && rsp_ready && sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_result",   int'(rsp_result),   int'(e.res));
            chk("rsp_zero",     int'(rsp_zero),     int'(e.z));
            chk("rsp_overflow", int'(rsp_overflow), int'(e.o));
            chk("acc_out",      int'(acc_out),      int'(e.acc));
            chk("ovf_sticky",   int'(ovf_sticky),   int'(e.st));
            chk("enable_window", en_cnt, 2);
            en_cnt = 0;
         end
         prev_v = rsp_valid;
      end
   end

   // Called at posedge+1; returns at posedge+1 of the ISSUE cycle with
   // cmd_valid still high.
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ua, input logic [3:0] er, input logic ez, input logic eo,
                       input logic [3:0] eacc, input logic est, input bit push);
      exp_t e;
      int   n;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!cmd_ready) begin
         chk("accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      e.res = er; e.z = ez; e.o = eo; e.acc = eacc; e.st = est; e.t_acc = cyc;
      last_acc = cyc;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n;
      cmd_valid = 1'b0;
      n = 0;
      while (!cmd_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!cmd_ready) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, t2, n, seen;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_use_acc = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_ready",  int'(cmd_ready),  1);
      chk("rst_rsp_valid",  int'(rsp_valid),  0);
      chk("rst_alu_enable", int'(alu_enable), 0);
      chk("rst_alu_a",      int'(alu_a),      0);
      chk("rst_alu_b",      int'(alu_b),      0);
      chk("rst_alu_ctrl",   int'(alu_ctrl),   0);
      chk("rst_rsp_result", int'(rsp_result), 0);
      chk("rst_acc_out",    int'(acc_out),    0);
      chk("rst_ovf_sticky", int'(ovf_sticky), 0);
      chk("rst_busy",       int'(busy),       0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic add, carry-out overflow, masked logic op.
      send(3'b000, 4'd3,  4'd2, 1'b0, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0, 1); wait_idle();
      send(3'b000, 4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1); wait_idle();
      send(3'b010, 4'd15, 4'd15,1'b0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b1, 1); wait_idle();

      // acc_clr coincident with capture: acc takes result, sticky only new flag.
      send(3'b000, 4'd2, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1);
      cmd_valid = 1'b0;
      @(posedge clk); #1; acc_clr = 1'b1;
      @(posedge clk); #1; acc_clr = 1'b0;
      wait_idle();

      // acc_clr at accept with use_acc: A is the pre-clear accumulator (5).
      acc_clr = 1'b1;
      send(3'b000, 4'd9, 4'd1, 1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 1);
      acc_clr = 1'b0;
      wait_idle();

      // Set sticky, then a standalone clear pulse.
      send(3'b000, 4'd9, 4'd9, 1'b0, 4'd2, 1'b0, 1'b1, 4'd2, 1'b1, 1); wait_idle();
      acc_clr = 1'b1;
      @(posedge clk); #1; acc_clr = 1'b0;
      chk("clr_acc_out",    int'(acc_out),    0);
      chk("clr_ovf_sticky", int'(ovf_sticky), 0);

      // Accumulator chain: 4, 4-1=3, ~3=12.
      send(3'b000, 4'd4, 4'd0, 1'b0, 4'd4,  1'b0, 1'b0, 4'd4,  1'b0, 1); wait_idle();
      send(3'b001, 4'd9, 4'd1, 1'b1, 4'd3,  1'b0, 1'b0, 4'd3,  1'b0, 1); wait_idle();
      send(3'b111, 4'd9, 4'd0, 1'b1, 4'd12, 1'b0, 1'b0, 4'd12, 1'b0, 1); wait_idle();

      // Backpressure: response must hold for 5 cycles with cmd_ready low.
      rsp_ready = 1'b0;
      send(3'b100, 4'd5, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 1);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("bp_rsp_valid_seen", int'(rsp_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_rsp_valid_hold",  int'(rsp_valid),  1);
         chk("bp_rsp_result_hold", int'(rsp_result), 6);
         chk("bp_cmd_ready_low",   int'(cmd_ready),  0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_busy",      int'(busy),      0);
      chk("bp_idle_cmd_ready", int'(cmd_ready), 1);

      // Reset during CAPTURE: enable drops at once, no response, acc reset.
      send(3'b000, 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 4'd2, 1'b0, 0);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_enable_before", int'(alu_enable), 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_enable_async", int'(alu_enable), 0);
      chk("rstmid_busy",         int'(busy),       0);
      @(posedge clk); #1; rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) seen++;
      end
      chk("rstmid_no_rsp",  seen,              0);
      chk("rstmid_acc_out", int'(acc_out),     0);
      chk("rstmid_sticky",  int'(ovf_sticky),  0);

      // Back-to-back commands with cmd_valid held: accepts 4 cycles apart.
      send(3'b011, 4'd5,  4'd10, 1'b0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1); t0 = last_acc;
      send(3'b101, 4'd15, 4'd15, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  1'b0, 1); t1 = last_acc;
      send(3'b110, 4'd0,  4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1); t2 = last_acc;
      wait_idle();
      chk("spacing_1", t1 - t0, 4);
      chk("spacing_2", t2 - t1, 4);

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
